// File: rtl/pll_div_pkg.sv
// Shared constants and ratio helpers for the programmable PLL feedback divider.
package pll_div_pkg;

    localparam int unsigned DIV_WIDTH = 8;
    localparam int unsigned DIV_RESET = 32;
    localparam int unsigned DIV_MIN   = 2;

    function automatic int unsigned clamp_div(input int unsigned n, input int unsigned lo);
        return (n < lo) ? lo : n;
    endfunction

    // High-phase length: odd ratios get the extra cycle in the high phase.
    function automatic int unsigned hi_len(input int unsigned n);
        return (n >> 1) + (n & 32'd1);
    endfunction

endpackage

// File: rtl/pll_divn_prog_if.sv
// Control/status bundle of the feedback divider; _i/_o named from the divider's side.
interface pll_divn_prog_if import pll_div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             pwrup_1v8_i;
    logic [WIDTH-1:0] div_n_i;
    logic             div_load_i;
    logic             div_ack_o;
    logic             ck_fb_o;
    logic             fb_pulse_o;
    logic [WIDTH-1:0] div_active_o;
    logic             pending_o;

    modport master (
        output pwrup_1v8_i, div_n_i, div_load_i,
        input  div_ack_o, ck_fb_o, fb_pulse_o, div_active_o, pending_o
    );

    modport slave (
        input  pwrup_1v8_i, div_n_i, div_load_i,
        output div_ack_o, ck_fb_o, fb_pulse_o, div_active_o, pending_o
    );
endinterface

// File: rtl/pll_div_shadow.sv
// Shadow ratio register: captures requests and promotes them to the active ratio
// only when the counter signals a safe boundary.
module pll_div_shadow import pll_div_pkg::*; #(
    parameter int unsigned WIDTH     = DIV_WIDTH,
    parameter int unsigned RESET_DIV = DIV_RESET,
    parameter int unsigned MIN_DIV   = DIV_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] div_n_i,
    input  logic             apply_i,
    output logic [WIDTH-1:0] active_o,
    output logic             pending_o,
    output logic             ack_o
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        if (apply_i && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end
        // A load on the apply edge wins: it stays pending for the next boundary.
        if (load_i) begin
            shadow_d  = WIDTH'(clamp_div(32'(div_n_i), MIN_DIV));
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= WIDTH'(RESET_DIV);
            active_q  <= WIDTH'(RESET_DIV);
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
        end
    end

    assign active_o  = active_q;
    assign pending_o = pending_q;
    assign ack_o     = ack_q;

endmodule

// File: rtl/pll_divn_prog.sv
// Programmable feedback divider: synchronous mod-N counter producing a registered
// near-50% CK_FB and a wrap pulse, with glitch-free ratio changes at period boundaries.
module pll_divn_prog import pll_div_pkg::*; #(
    parameter int unsigned WIDTH     = DIV_WIDTH,
    parameter int unsigned RESET_DIV = DIV_RESET,
    parameter int unsigned MIN_DIV   = DIV_MIN
) (
    input  logic           clk,
    input  logic           rst,
    pll_divn_prog_if.slave bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] div_active;
    logic             ck_fb_q, ck_fb_d;
    logic             fb_pulse_q, fb_pulse_d;
    logic             wrap;
    logic             apply;
    logic             pending;
    logic             div_ack;

    always_comb begin
        cnt_inc    = (cnt_q == div_active - WIDTH'(1)) ? '0 : cnt_q + WIDTH'(1);
        wrap       = (cnt_inc == '0);
        hi_n       = WIDTH'(hi_len(32'(div_active)));
        cnt_d      = '0;
        ck_fb_d    = 1'b0;
        fb_pulse_d = 1'b0;
        // Idle parks the counter, so a pending ratio is safe to apply on any edge.
        apply      = 1'b1;
        if (bus.pwrup_1v8_i) begin
            cnt_d      = cnt_inc;
            ck_fb_d    = (cnt_inc < hi_n);
            fb_pulse_d = wrap;
            apply      = wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            ck_fb_q    <= 1'b0;
            fb_pulse_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ck_fb_q    <= ck_fb_d;
            fb_pulse_q <= fb_pulse_d;
        end
    end

    pll_div_shadow #(
        .WIDTH     (WIDTH),
        .RESET_DIV (RESET_DIV),
        .MIN_DIV   (MIN_DIV)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .load_i    (bus.div_load_i),
        .div_n_i   (bus.div_n_i),
        .apply_i   (apply),
        .active_o  (div_active),
        .pending_o (pending),
        .ack_o     (div_ack)
    );

    assign bus.ck_fb_o      = ck_fb_q;
    assign bus.fb_pulse_o   = fb_pulse_q;
    assign bus.div_active_o = div_active;
    assign bus.pending_o    = pending;
    assign bus.div_ack_o    = div_ack;

endmodule
